acc_stage: RTL and testbench

//  Accumulate stage of the Euler pipeline. It sits directly downstream of mul_stage.
//  - Sums the signed products of one matrix row into a dot product.
//  - Holds the result in a one-entry output buffer with a valid/ready handshake.
//  - Signals done_mul_acc to FSM_END_EULAR when the row result is consumed.
//  - Tracks the current row index.
//

---
 rtl/acc_stage_if.sv | 29 ++
 rtl/acc_stage.sv | 162 ++++++++++++++++
 tb/tb_acc_stage.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/acc_stage_if.sv
// Handshake bundle between mul_stage, acc_stage and the result consumer.
// The master side is the environment: it produces products and consumes results.
// The slave side is acc_stage itself.
interface acc_stage_if #(
  parameter int DATA_SIZE = 16,
  parameter int MAX_DIM   = 6
);
  logic                 prod_valid;
  logic [DATA_SIZE-1:0] prod_data;
  logic                 prod_ovf;
  logic                 prod_last;
  logic                 acc_ready;
  logic                 res_valid;
  logic                 res_ready;
  logic [DATA_SIZE-1:0] res_data;
  logic                 res_ovf;
  logic [MAX_DIM-1:0]   row_idx;
  logic                 done_mul_acc;

  modport master (
    output prod_valid, prod_data, prod_ovf, prod_last, res_ready,
    input  acc_ready, res_valid, res_data, res_ovf, row_idx, done_mul_acc
  );

  modport slave (
    input  prod_valid, prod_data, prod_ovf, prod_last, res_ready,
    output acc_ready, res_valid, res_data, res_ovf, row_idx, done_mul_acc
  );
endinterface

// File: rtl/acc_stage.sv
// Accumulate stage of the Euler pipeline.
// Sums the signed products of one matrix row into a dot product, buffers the
// row result behind a valid/ready handshake, pulses done_mul_acc when the
// result is consumed and tracks the current row index.
// Optional feature macro ACC_SAT_EN: when defined, the row result saturates to
// the signed DATA_SIZE range instead of wrapping. res_ovf is the same in both modes.
module acc_stage #(
  parameter int DATA_SIZE = 16,
  parameter int MAX_DIM   = 6,
  parameter int GUARD     = 4,
  parameter int ROWS      = 2
) (
  input  logic         clk,
  input  logic         rst,
  acc_stage_if.slave   bus
);

  localparam int ACC_W = DATA_SIZE + GUARD;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_next_s;
  logic [ACC_W-1:0]     acc_r;
  logic [ACC_W-1:0]     acc_next_s;
  logic                 ovf_row_r;
  logic                 ovf_row_next_s;
  logic [DATA_SIZE-1:0] res_data_r;
  logic                 res_ovf_r;
  logic                 res_valid_r;
  logic [MAX_DIM-1:0]   row_idx_r;
  logic                 done_r;
  logic                 accept_s;
  logic                 load_res_s;
  logic                 handshake_s;
  logic [ACC_W-1:0]     prod_sext_s;

  // True when the wide sum fits the signed DATA_SIZE range (guard bits all copy the sign).
  function automatic logic fits_range(input logic [ACC_W-1:0] v);
    logic [GUARD:0] upper;
    upper = v[ACC_W-1:DATA_SIZE-1];
    return (upper == {(GUARD+1){1'b0}}) || (upper == {(GUARD+1){1'b1}});
  endfunction

  // Narrow the wide sum to the result width.
  function automatic logic [DATA_SIZE-1:0] narrow(input logic [ACC_W-1:0] v);
`ifdef ACC_SAT_EN
    logic [DATA_SIZE-1:0] r;
    if (fits_range(v)) begin
      r = v[DATA_SIZE-1:0];
    end else if (v[ACC_W-1]) begin
      r = {1'b1, {(DATA_SIZE-1){1'b0}}};
    end else begin
      r = {1'b0, {(DATA_SIZE-1){1'b1}}};
    end
    return r;
`else
    return v[DATA_SIZE-1:0];
`endif
  endfunction

  assign prod_sext_s = {{GUARD{bus.prod_data[DATA_SIZE-1]}}, bus.prod_data};
  assign accept_s    = bus.prod_valid && (state_r != HOLD);
  assign load_res_s  = accept_s && bus.prod_last;
  assign handshake_s = res_valid_r && bus.res_ready;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state plus next partial sum / row overflow flag.
  always_comb begin
    state_next_s   = state_r;
    acc_next_s     = acc_r;
    ovf_row_next_s = ovf_row_r;
    case (state_r)
      IDLE: begin
        if (bus.prod_valid) begin
          acc_next_s     = prod_sext_s;
          ovf_row_next_s = bus.prod_ovf;
          state_next_s   = bus.prod_last ? HOLD : ACCUM;
        end else begin
          state_next_s   = IDLE;
        end
      end
      ACCUM: begin
        if (bus.prod_valid) begin
          acc_next_s     = acc_r + prod_sext_s;
          ovf_row_next_s = ovf_row_r | bus.prod_ovf;
          state_next_s   = bus.prod_last ? HOLD : ACCUM;
        end else begin
          state_next_s   = ACCUM;
        end
      end
      HOLD: begin
        if (handshake_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = HOLD;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Accumulator, result buffer, row counter and completion pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_r       <= {ACC_W{1'b0}};
      ovf_row_r   <= 1'b0;
      res_data_r  <= {DATA_SIZE{1'b0}};
      res_ovf_r   <= 1'b0;
      res_valid_r <= 1'b0;
      row_idx_r   <= {MAX_DIM{1'b0}};
      done_r      <= 1'b0;
    end else begin
      acc_r     <= acc_next_s;
      ovf_row_r <= ovf_row_next_s;
      done_r    <= handshake_s;
      if (load_res_s) begin
        res_data_r  <= narrow(acc_next_s);
        res_ovf_r   <= ovf_row_next_s | ~fits_range(acc_next_s);
        res_valid_r <= 1'b1;
      end else if (handshake_s) begin
        res_valid_r <= 1'b0;
      end else begin
        res_valid_r <= res_valid_r;
      end
      if (handshake_s) begin
        if (row_idx_r == MAX_DIM'(ROWS - 1)) begin
          row_idx_r <= {MAX_DIM{1'b0}};
        end else begin
          row_idx_r <= row_idx_r + {{(MAX_DIM-1){1'b0}}, 1'b1};
        end
      end else begin
        row_idx_r <= row_idx_r;
      end
    end
  end

  // Drive the interface outputs from registered state.
  always_comb begin
    bus.acc_ready    = (state_r != HOLD);
    bus.res_valid    = res_valid_r;
    bus.res_data     = res_data_r;
    bus.res_ovf      = res_ovf_r;
    bus.row_idx      = row_idx_r;
    bus.done_mul_acc = done_r;
  end

endmodule

// File: tb/tb_acc_stage.sv
// Directed testbench for acc_stage (DATA_SIZE=16, GUARD=4, ROWS=2).
// Expected results are hand-computed; test 2 depends on ACC_SAT_EN.
module tb_acc_stage;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   exp_row;

  acc_stage_if #(.DATA_SIZE(16), .MAX_DIM(6)) bus ();

  acc_stage #(.DATA_SIZE(16), .MAX_DIM(6), .GUARD(4), .ROWS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [15:0] d, input logic ovf, input logic last);
    bus.prod_valid = 1'b1;
    bus.prod_data  = d;
    bus.prod_ovf   = ovf;
    bus.prod_last  = last;
    step();
    bus.prod_valid = 1'b0;
    bus.prod_ovf   = 1'b0;
    bus.prod_last  = 1'b0;
  endtask

  // Result must be visible right after the last product; consume it and check the pulse.
  task automatic collect(input string tag, input logic [15:0] d, input logic ovf);
    bus.res_ready = 1'b1;
    check({tag, "_valid"},   32'(bus.res_valid), 32'd1);
    check({tag, "_data"},    32'(bus.res_data), 32'(d));
    check({tag, "_ovf"},     32'(bus.res_ovf), 32'(ovf));
    check({tag, "_row"},     32'(bus.row_idx), 32'(exp_row));
    check({tag, "_ready0"},  32'(bus.acc_ready), 32'd0);
    step();
    exp_row = (exp_row == 1) ? 0 : exp_row + 1;
    check({tag, "_done"},    32'(bus.done_mul_acc), 32'd1);
    check({tag, "_vdrop"},   32'(bus.res_valid), 32'd0);
    check({tag, "_rownext"}, 32'(bus.row_idx), 32'(exp_row));
    step();
    check({tag, "_done1cy"}, 32'(bus.done_mul_acc), 32'd0);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    exp_row        = 0;
    rst            = 1'b0;
    bus.prod_valid = 1'b0;
    bus.prod_data  = 16'd0;
    bus.prod_ovf   = 1'b0;
    bus.prod_last  = 1'b0;
    bus.res_ready  = 1'b0;
    step();
    step();
    check("rst_valid", 32'(bus.res_valid), 32'd0);
    check("rst_ready", 32'(bus.acc_ready), 32'd1);
    check("rst_row",   32'(bus.row_idx), 32'd0);
    check("rst_done",  32'(bus.done_mul_acc), 32'd0);
    check("rst_data",  32'(bus.res_data), 32'd0);
    check("rst_ovf",   32'(bus.res_ovf), 32'd0);
    rst = 1'b1;
    step();

    // 1: 3 + 5
    bus.res_ready = 1'b1;
    put(16'd3, 1'b0, 1'b0);
    check("t1_mid_valid", 32'(bus.res_valid), 32'd0);
    check("t1_mid_ready", 32'(bus.acc_ready), 32'd1);
    put(16'd5, 1'b0, 1'b1);
    collect("t1", 16'd8, 1'b0);

    // 2: 0x7000 + 0x2000 overflows the signed 16-bit range
    put(16'h7000, 1'b0, 1'b0);
    put(16'h2000, 1'b0, 1'b1);
`ifdef ACC_SAT_EN
    collect("t2", 16'h7FFF, 1'b1);
`else
    collect("t2", 16'h9000, 1'b1);
`endif

    // 3: result held while products are offered and must be ignored
    bus.res_ready = 1'b0;
    put(16'd6, 1'b0, 1'b0);
    put(16'd4, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bus.prod_valid = 1'b1;
      bus.prod_data  = 16'd9;
      bus.prod_last  = 1'b1;
      check("t3_hold_ready", 32'(bus.acc_ready), 32'd0);
      check("t3_hold_data",  32'(bus.res_data), 32'd10);
      check("t3_hold_valid", 32'(bus.res_valid), 32'd1);
      step();
    end
    bus.prod_valid = 1'b0;
    bus.prod_last  = 1'b0;
    collect("t3", 16'd10, 1'b0);
    put(16'd4, 1'b0, 1'b1);
    collect("t3_next", 16'd4, 1'b0);

    // 4: prod_last alone is ignored, then three single-product rows
    bus.prod_last = 1'b1;
    step();
    bus.prod_last = 1'b0;
    check("t4_lastonly", 32'(bus.res_valid), 32'd0);
    step();
    check("t4_lastonly2", 32'(bus.res_valid), 32'd0);
    put(16'd1, 1'b0, 1'b1);
    collect("t4a", 16'd1, 1'b0);
    put(16'd2, 1'b0, 1'b1);
    collect("t4b", 16'd2, 1'b0);
    put(16'd3, 1'b0, 1'b1);
    collect("t4c", 16'd3, 1'b0);

    // 5: reset aborts a partial row
    put(16'd7, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    exp_row = 0;
    check("t5_valid", 32'(bus.res_valid), 32'd0);
    check("t5_row",   32'(bus.row_idx), 32'd0);
    check("t5_ready", 32'(bus.acc_ready), 32'd1);
    put(16'd2, 1'b0, 1'b0);
    check("t5_mid", 32'(bus.res_valid), 32'd0);
    put(16'd4, 1'b0, 1'b1);
    collect("t5", 16'd6, 1'b0);

    // 6: overflow flag is per row; clean row with a negative sum
    put(16'd5, 1'b1, 1'b0);
    put(16'd1, 1'b0, 1'b1);
    collect("t6a", 16'd6, 1'b1);
    put(16'hFFFD, 1'b0, 1'b0);
    put(16'd1, 1'b0, 1'b1);
    collect("t6b", 16'hFFFE, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
